// File: rtl/riscv_regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : riscv_regfile_mp                                             |
// | Description : Parametrised multi-port integer register file for the rv32   |
// |               core. NUM_RD asynchronous read ports, two synchronous write  |
// |               ports (wr0 = ALU writeback, wr1 = LSU writeback) and a       |
// |               per-register busy scoreboard for RAW hazard detection.       |
// |               Register 0 is hardwired to zero and is never busy.           |
// | Option      : REGFILE_BYPASS_EN - same-cycle write-to-read forwarding of   |
// |               data, with busy masking for registers written this cycle.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module riscv_regfile_mp #(
  parameter int  XLEN     = 32,
  parameter int  NUM_REGS = 32,
  parameter int  NUM_RD   = 2,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr0_en_i,
  input  logic [AW-1:0]          wr0_addr_i,
  input  logic [XLEN-1:0]        wr0_data_i,
  input  logic                   wr1_en_i,
  input  logic [AW-1:0]          wr1_addr_i,
  input  logic [XLEN-1:0]        wr1_data_i,
  input  logic                   issue_en_i,
  input  logic [AW-1:0]          issue_rd_i,
  input  logic [NUM_RD*AW-1:0]   rd_addr_i,
  output logic [NUM_RD*XLEN-1:0] rd_data_o,
  output logic [NUM_RD-1:0]      rd_busy_o,
  output logic                   any_busy_o
);

  localparam logic [AW-1:0] c_X0 = '0;

  // Register 0 is never written, so it holds the reset value 0 forever and
  // reads of x0 need no special-case mux.
  logic [XLEN-1:0]     r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;

  // Register array update: wr1 is applied after wr0 so it wins a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (wr0_en_i && (wr0_addr_i != c_X0)) begin
        r_regs[wr0_addr_i] <= wr0_data_i;
      end
      if (wr1_en_i && (wr1_addr_i != c_X0)) begin
        r_regs[wr1_addr_i] <= wr1_data_i;
      end
    end
  end

  // Next busy state: writebacks clear, then issue sets so a new producer
  // supersedes a completing one on the same register.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wr0_en_i) begin
      w_busy_nxt[wr0_addr_i] = 1'b0;
    end
    if (wr1_en_i) begin
      w_busy_nxt[wr1_addr_i] = 1'b0;
    end
    if (issue_en_i) begin
      w_busy_nxt[issue_rd_i] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Busy scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign any_busy_o = |r_busy;

  genvar k;
  generate
    for (k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0] w_addr;
      assign w_addr = rd_addr_i[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      logic w_hit0;
      logic w_hit1;
      logic w_issue_hit;
      assign w_hit0      = wr0_en_i && (wr0_addr_i == w_addr) && (w_addr != c_X0);
      assign w_hit1      = wr1_en_i && (wr1_addr_i == w_addr) && (w_addr != c_X0);
      assign w_issue_hit = issue_en_i && (issue_rd_i == w_addr);
      // Forward the in-flight write (wr1 has priority) ahead of the stored value.
      assign rd_data_o[k*XLEN +: XLEN] = w_hit1 ? wr1_data_i :
                                         w_hit0 ? wr0_data_i :
                                                  r_regs[w_addr];
      // A register being written this cycle is not busy to the reader, unless
      // a fresh producer for it is issuing in the same cycle.
      assign rd_busy_o[k] = ((w_hit0 || w_hit1) && !w_issue_hit) ? 1'b0 : r_busy[w_addr];
`else
      assign rd_data_o[k*XLEN +: XLEN] = r_regs[w_addr];
      assign rd_busy_o[k]              = r_busy[w_addr];
`endif
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_riscv_regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_riscv_regfile_mp                                          |
// | Description : Self-checking bench for riscv_regfile_mp (NUM_REGS=16,       |
// |               NUM_RD=3): directed vector table, hand-written multi-cycle   |
// |               sequences and a randomised run against a reference model.    |
// |               Expectations follow REGFILE_BYPASS_EN when it is defined.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_riscv_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 16;
  localparam int NRD  = 3;
  localparam int AW   = 4;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              wr0_en, wr1_en, issue_en;
  logic [AW-1:0]     wr0_addr, wr1_addr, issue_rd;
  logic [XLEN-1:0]   wr0_data, wr1_data;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              any_busy;

  riscv_regfile_mp #(.XLEN(XLEN), .NUM_REGS(NREG), .NUM_RD(NRD)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr0_en_i   (wr0_en),
    .wr0_addr_i (wr0_addr),
    .wr0_data_i (wr0_data),
    .wr1_en_i   (wr1_en),
    .wr1_addr_i (wr1_addr),
    .wr1_data_i (wr1_data),
    .issue_en_i (issue_en),
    .issue_rd_i (issue_rd),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .rd_busy_o  (rd_busy),
    .any_busy_o (any_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            w0e;
    logic [AW-1:0]   w0a;
    logic [XLEN-1:0] w0d;
    logic            w1e;
    logic [AW-1:0]   w1a;
    logic [XLEN-1:0] w1d;
    logic            ie;
    logic [AW-1:0]   ird;
    logic [AW-1:0]   ra [NRD];
    logic [XLEN-1:0] ed [NRD];
    logic [NRD-1:0]  eb;
    logic            ea;
  } vec_t;

  vec_t vecs [13];
  int   n_pass = 0;
  int   n_total = 0;

  logic [XLEN-1:0] m_regs [NREG];
  logic [NREG-1:0] m_busy;

  function automatic vec_t mk(input int w0e, input int w0a, input logic [XLEN-1:0] w0d,
                              input int w1e, input int w1a, input logic [XLEN-1:0] w1d,
                              input int ie, input int ird,
                              input int ra0, input int ra1, input int ra2,
                              input logic [XLEN-1:0] ed0, input logic [XLEN-1:0] ed1,
                              input logic [XLEN-1:0] ed2, input int eb, input int ea);
    vec_t v;
    v.w0e = 1'(w0e); v.w0a = AW'(w0a); v.w0d = w0d;
    v.w1e = 1'(w1e); v.w1a = AW'(w1a); v.w1d = w1d;
    v.ie  = 1'(ie);  v.ird = AW'(ird);
    v.ra[0] = AW'(ra0); v.ra[1] = AW'(ra1); v.ra[2] = AW'(ra2);
    v.ed[0] = ed0; v.ed[1] = ed1; v.ed[2] = ed2;
    v.eb = NRD'(eb); v.ea = 1'(ea);
    return v;
  endfunction

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input int w0e, input int w0a, input logic [XLEN-1:0] w0d,
                       input int w1e, input int w1a, input logic [XLEN-1:0] w1d,
                       input int ie, input int ird, input int ra0, input int ra1, input int ra2);
    wr0_en = 1'(w0e); wr0_addr = AW'(w0a); wr0_data = w0d;
    wr1_en = 1'(w1e); wr1_addr = AW'(w1a); wr1_data = w1d;
    issue_en = 1'(ie); issue_rd = AW'(ird);
    rd_addr = {AW'(ra2), AW'(ra1), AW'(ra0)};
  endtask

  task automatic idle_read(input int ra0, input int ra1, input int ra2);
    drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, ra0, ra1, ra2);
  endtask

  // Settle combinational outputs mid-cycle, then advance past the next edge.
  task automatic settle();
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            b, h0, h1;

    rst = 1'b1;
    idle_read(0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed table: each row is one cycle; expectations are the outputs
    // seen during that cycle (before its closing edge).
    vecs[0]  = mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 1, 2, 3, 32'h0, 32'h0, 32'h0, 3'b000, 0);
    vecs[1]  = mk(1, 1, 32'h11111111, 1, 2, 32'h22222222, 0, 0, 4, 5, 6, 32'h0, 32'h0, 32'h0, 3'b000, 0);
    vecs[2]  = mk(0, 0, 32'h0, 0, 0, 32'h0, 1, 4, 1, 2, 0, 32'h11111111, 32'h22222222, 32'h0, 3'b000, 0);
    vecs[3]  = mk(1, 7, 32'hAAAA0000, 1, 7, 32'h5555FFFF, 0, 0, 4, 1, 2, 32'h0, 32'h11111111, 32'h22222222, 3'b001, 1);
    vecs[4]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, 32'h0, 1, 0, 7, 0, 4, 32'h5555FFFF, 32'h0, 32'h0, 3'b100, 1);
    vecs[5]  = mk(0, 0, 32'h0, 1, 4, 32'h44, 0, 0, 0, 7, 7, 32'h0, 32'h5555FFFF, 32'h5555FFFF, 3'b000, 1);
    vecs[6]  = mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 4, 0, 4, 32'h44, 32'h0, 32'h44, 3'b000, 0);
    vecs[7]  = mk(1, 10, 32'h10, 0, 0, 32'h0, 1, 10, 1, 2, 3, 32'h11111111, 32'h22222222, 32'h0, 3'b000, 0);
    vecs[8]  = mk(0, 0, 32'h0, 0, 0, 32'h0, 1, 10, 10, 10, 1, 32'h10, 32'h10, 32'h11111111, 3'b011, 1);
    vecs[9]  = mk(1, 15, 32'hF, 0, 0, 32'h0, 0, 0, 10, 14, 13, 32'h10, 32'h0, 32'h0, 3'b001, 1);
    vecs[10] = mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 15, 10, 0, 32'hF, 32'h10, 32'h0, 3'b010, 1);
    vecs[11] = mk(0, 0, 32'h0, 1, 10, 32'h42, 0, 0, 15, 1, 2, 32'hF, 32'h11111111, 32'h22222222, 3'b000, 1);
    vecs[12] = mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 10, 10, 10, 32'h42, 32'h42, 32'h42, 3'b000, 0);

    for (int i = 0; i < 13; i++) begin
      drive(int'(vecs[i].w0e), int'(vecs[i].w0a), vecs[i].w0d,
            int'(vecs[i].w1e), int'(vecs[i].w1a), vecs[i].w1d,
            int'(vecs[i].ie), int'(vecs[i].ird),
            int'(vecs[i].ra[0]), int'(vecs[i].ra[1]), int'(vecs[i].ra[2]));
      settle();
      for (int k = 0; k < NRD; k++) begin
        chk($sformatf("vec%0d_data%0d", i, k), rd_data[k*XLEN +: XLEN], vecs[i].ed[k]);
      end
      chk($sformatf("vec%0d_busy", i), 32'(rd_busy), 32'(vecs[i].eb));
      chk($sformatf("vec%0d_any", i), 32'(any_busy), 32'(vecs[i].ea));
      tick();
    end

    // Same-cycle write and read of x3.
    drive(1, 3, 32'hDEAD, 0, 0, 32'h0, 0, 0, 3, 3, 3);
    settle();
    chk("byp_x3_data", rd_data[0 +: XLEN], BYP ? 32'hDEAD : 32'h0);
    chk("byp_x3_busy", 32'(rd_busy), 32'h0);
    tick();
    idle_read(3, 3, 3);
    settle();
    chk("x3_next_cycle", rd_data[2*XLEN +: XLEN], 32'hDEAD);

    // Writeback to a busy register read in the same cycle.
    tick();
    drive(0, 0, 32'h0, 0, 0, 32'h0, 1, 5, 5, 5, 5);
    tick();
    drive(1, 5, 32'h55, 0, 0, 32'h0, 0, 0, 5, 5, 5);
    settle();
    chk("wb_busy_same_cycle", 32'(rd_busy[0]), BYP ? 32'h0 : 32'h1);
    chk("wb_data_same_cycle", rd_data[XLEN +: XLEN], BYP ? 32'h55 : 32'h0);
    tick();
    idle_read(5, 5, 5);
    settle();
    chk("wb_busy_after", 32'(rd_busy), 32'h0);
    chk("wb_data_after", rd_data[0 +: XLEN], 32'h55);
    chk("wb_any_after", 32'(any_busy), 32'h0);

    // Writeback plus re-issue of the same busy register.
    tick();
    drive(0, 0, 32'h0, 0, 0, 32'h0, 1, 6, 6, 6, 6);
    tick();
    drive(0, 0, 32'h0, 1, 6, 32'h66, 1, 6, 6, 6, 6);
    settle();
    chk("reissue_busy_same", 32'(rd_busy), 32'h7);
    chk("reissue_data_same", rd_data[XLEN +: XLEN], BYP ? 32'h66 : 32'h0);
    tick();
    idle_read(6, 6, 6);
    settle();
    chk("reissue_busy_after", 32'(rd_busy), 32'h7);
    chk("reissue_data_after", rd_data[0 +: XLEN], 32'h66);
    chk("reissue_any_after", 32'(any_busy), 32'h1);
    tick();
    drive(1, 6, 32'h66, 0, 0, 32'h0, 0, 0, 6, 6, 6);
    tick();

    // Both write ports hit the register being read.
    drive(1, 8, 32'hA, 1, 8, 32'hB, 0, 0, 8, 8, 8);
    settle();
    chk("dual_byp_x8", rd_data[2*XLEN +: XLEN], BYP ? 32'hB : 32'h0);
    tick();
    idle_read(8, 8, 8);
    settle();
    chk("dual_x8_after", rd_data[XLEN +: XLEN], 32'hB);

    // Reset mid-operation with a write and an issue in the reset cycle.
    tick();
    drive(1, 5, 32'h1234, 0, 0, 32'h0, 0, 0, 5, 9, 0);
    tick();
    drive(0, 0, 32'h0, 0, 0, 32'h0, 1, 9, 5, 9, 0);
    tick();
    idle_read(5, 9, 0);
    settle();
    chk("pre_rst_x5", rd_data[0 +: XLEN], 32'h1234);
    chk("pre_rst_busy", 32'(rd_busy), 32'h2);
    rst = 1'b1;
    drive(1, 11, 32'h77, 0, 0, 32'h0, 1, 12, 5, 9, 0);
    tick();
    rst = 1'b0;
    idle_read(5, 11, 12);
    settle();
    chk("rst_x5", rd_data[0 +: XLEN], 32'h0);
    chk("rst_x11", rd_data[XLEN +: XLEN], 32'h0);
    chk("rst_x12", rd_data[2*XLEN +: XLEN], 32'h0);
    chk("rst_busy", 32'(rd_busy), 32'h0);
    chk("rst_any", 32'(any_busy), 32'h0);
    tick();

    // Randomised run against a reference model (state here is all-zero).
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    m_busy = '0;
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive(int'($urandom_range(0, 1)), int'($urandom_range(0, NREG-1)), $urandom,
            int'($urandom_range(0, 1)), int'($urandom_range(0, NREG-1)), $urandom,
            int'($urandom_range(0, 1)), int'($urandom_range(0, NREG-1)),
            int'($urandom_range(0, NREG-1)), int'($urandom_range(0, NREG-1)),
            int'($urandom_range(0, NREG-1)));
      settle();
      for (int k = 0; k < NRD; k++) begin
        a = rd_addr[k*AW +: AW];
        d = (a == 0) ? 32'h0 : m_regs[a];
        b = (a == 0) ? 1'b0 : m_busy[a];
        if (BYP && (a != 0)) begin
          h0 = wr0_en && (wr0_addr == a);
          h1 = wr1_en && (wr1_addr == a);
          if (h1) d = wr1_data;
          else if (h0) d = wr0_data;
          if ((h0 || h1) && !(issue_en && (issue_rd == a))) b = 1'b0;
        end
        chk($sformatf("rnd%0d_data%0d", c, k), rd_data[k*XLEN +: XLEN], d);
        chk($sformatf("rnd%0d_busy%0d", c, k), 32'(rd_busy[k]), 32'(b));
      end
      chk($sformatf("rnd%0d_any", c), 32'(any_busy), 32'(|m_busy));
      if (rst) begin
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        m_busy = '0;
      end else begin
        if (wr0_en && wr0_addr != 0) m_regs[wr0_addr] = wr0_data;
        if (wr1_en && wr1_addr != 0) m_regs[wr1_addr] = wr1_data;
        if (wr0_en) m_busy[wr0_addr] = 1'b0;
        if (wr1_en) m_busy[wr1_addr] = 1'b0;
        if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      end
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
